// File: rtl/axi_lite_bram_ctrl.sv
// AXI4-Lite slave bridging single-beat reads/writes onto a native single-port BRAM.
// Write address and data are held independently; reads and writes alternate priority.
module axi_lite_bram_ctrl #(
    parameter int MEM_DATA_WIDTH  = 32,
    parameter int BRAM_ADDR_WIDTH = 7,
    parameter int AXI_ADDR_WIDTH  = 32
) (
    input  logic                          clka,
    input  logic                          rstn,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [MEM_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [MEM_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [MEM_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [BRAM_ADDR_WIDTH-1:0]    bram_addra,
    output logic                          bram_ena,
    output logic [MEM_DATA_WIDTH/8-1:0]   bram_wea,
    output logic [MEM_DATA_WIDTH-1:0]     bram_dina,
    input  logic [MEM_DATA_WIDTH-1:0]     bram_douta
);

    localparam int         STRB_WIDTH  = MEM_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, RD_ACCESS, RD_RESP, WR_RESP} state_t;

    state_t                        state_reg;
    logic                          active_reg;
    logic                          aw_held_reg;
    logic                          w_held_reg;
    logic                          last_was_read_reg;
    logic                          decerr_reg;
    logic [AXI_ADDR_WIDTH-1:0]     awaddr_reg;
    logic [MEM_DATA_WIDTH-1:0]     wdata_reg;
    logic [STRB_WIDTH-1:0]         wstrb_reg;
    logic [MEM_DATA_WIDTH-1:0]     rdata_reg;
    logic [1:0]                    rresp_reg;
    logic                          rvalid_reg;
    logic [1:0]                    bresp_reg;
    logic                          bvalid_reg;

    logic aw_hs;
    logic w_hs;
    logic rd_hs;
    logic grant_wr;
    logic rd_in_range;
    logic wr_in_range;
    logic rd_access;
    logic wr_access;

    // active_reg keeps every ready low until the first clock after reset release.
    assign s_axi_awready = active_reg & ~aw_held_reg;
    assign s_axi_wready  = active_reg & ~w_held_reg;
    assign aw_hs         = s_axi_awvalid & s_axi_awready;
    assign w_hs          = s_axi_wvalid & s_axi_wready;

    // A write competes only once both halves are already registered.
    assign grant_wr      = (state_reg == IDLE) & aw_held_reg & w_held_reg &
                           (~s_axi_arvalid | last_was_read_reg);
    assign s_axi_arready = active_reg & (state_reg == IDLE) & ~grant_wr;
    assign rd_hs         = s_axi_arvalid & s_axi_arready;

    assign rd_in_range   = (s_axi_araddr >> BRAM_ADDR_WIDTH) == '0;
    assign wr_in_range   = (awaddr_reg >> BRAM_ADDR_WIDTH) == '0;
    assign rd_access     = rd_hs & rd_in_range;
    assign wr_access     = grant_wr & wr_in_range;

    assign bram_ena   = rd_access | wr_access;
    assign bram_addra = grant_wr ? awaddr_reg[BRAM_ADDR_WIDTH-1:0]
                                 : s_axi_araddr[BRAM_ADDR_WIDTH-1:0];
    assign bram_dina  = wdata_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_wea
            assign bram_wea[gi] = wr_access & wstrb_reg[gi];
        end
    endgenerate

    assign s_axi_rdata  = rdata_reg;
    assign s_axi_rresp  = rresp_reg;
    assign s_axi_rvalid = rvalid_reg;
    assign s_axi_bresp  = bresp_reg;
    assign s_axi_bvalid = bvalid_reg;

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            state_reg         <= IDLE;
            active_reg        <= 1'b0;
            aw_held_reg       <= 1'b0;
            w_held_reg        <= 1'b0;
            last_was_read_reg <= 1'b0;
            decerr_reg        <= 1'b0;
            awaddr_reg        <= '0;
            wdata_reg         <= '0;
            wstrb_reg         <= '0;
            rdata_reg         <= '0;
            rresp_reg         <= RESP_OKAY;
            rvalid_reg        <= 1'b0;
            bresp_reg         <= RESP_OKAY;
            bvalid_reg        <= 1'b0;
        end else begin
            active_reg <= 1'b1;
            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                awaddr_reg  <= s_axi_awaddr;
            end
            if (w_hs) begin
                w_held_reg <= 1'b1;
                wdata_reg  <= s_axi_wdata;
                wstrb_reg  <= s_axi_wstrb;
            end
            case (state_reg)
                IDLE: begin
                    if (grant_wr) begin
                        aw_held_reg       <= 1'b0;
                        w_held_reg        <= 1'b0;
                        last_was_read_reg <= 1'b0;
                        bresp_reg         <= wr_in_range ? RESP_OKAY : RESP_DECERR;
                        bvalid_reg        <= 1'b1;
                        state_reg         <= WR_RESP;
                    end else if (rd_hs) begin
                        decerr_reg        <= ~rd_in_range;
                        last_was_read_reg <= 1'b1;
                        state_reg         <= RD_ACCESS;
                    end
                end
                RD_ACCESS: begin
                    rdata_reg  <= decerr_reg ? '0 : bram_douta;
                    rresp_reg  <= decerr_reg ? RESP_DECERR : RESP_OKAY;
                    rvalid_reg <= 1'b1;
                    state_reg  <= RD_RESP;
                end
                RD_RESP: begin
                    if (s_axi_rready) begin
                        rvalid_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_bram_ctrl.sv
// Bench for axi_lite_bram_ctrl: vector table, arbitration/reset sequences, and
// randomized traffic checked against a byte-array memory model.
module tb_axi_lite_bram_ctrl;

    localparam int DW  = 32;
    localparam int BAW = 7;
    localparam int AW  = 32;

    logic            clka = 1'b0;
    logic            rstn;
    logic [AW-1:0]   s_axi_awaddr;
    logic            s_axi_awvalid;
    logic            s_axi_awready;
    logic [DW-1:0]   s_axi_wdata;
    logic [DW/8-1:0] s_axi_wstrb;
    logic            s_axi_wvalid;
    logic            s_axi_wready;
    logic [1:0]      s_axi_bresp;
    logic            s_axi_bvalid;
    logic            s_axi_bready;
    logic [AW-1:0]   s_axi_araddr;
    logic            s_axi_arvalid;
    logic            s_axi_arready;
    logic [DW-1:0]   s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rvalid;
    logic            s_axi_rready;
    logic [BAW-1:0]  bram_addra;
    logic            bram_ena;
    logic [DW/8-1:0] bram_wea;
    logic [DW-1:0]   bram_dina;
    logic [DW-1:0]   bram_douta = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clka = ~clka;

    axi_lite_bram_ctrl #(
        .MEM_DATA_WIDTH (DW),
        .BRAM_ADDR_WIDTH(BAW),
        .AXI_ADDR_WIDTH (AW)
    ) dut (
        .clka         (clka),
        .rstn         (rstn),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .bram_addra   (bram_addra),
        .bram_ena     (bram_ena),
        .bram_wea     (bram_wea),
        .bram_dina    (bram_dina),
        .bram_douta   (bram_douta)
    );

    // Simple BRAM: word-indexed, one-cycle read latency, byte write enables.
    logic [DW-1:0] bram_mem [0:31] = '{default: '0};
    always @(posedge clka) begin
        if (bram_ena) begin
            bram_douta <= bram_mem[bram_addra[BAW-1:2]];
            for (int b = 0; b < DW/8; b++)
                if (bram_wea[b]) bram_mem[bram_addra[BAW-1:2]][8*b +: 8] <= bram_dina[8*b +: 8];
        end
    end

    // Reference model: 128 bytes of addressable memory, everything else decodes to error.
    logic [7:0] ref_bytes [0:127] = '{default: '0};

    function automatic bit ref_in_range(input logic [AW-1:0] a);
        return (a < 128);
    endfunction

    task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        int base;
        if (!ref_in_range(a)) return;
        base = (int'(a) / 4) * 4;
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_bytes[base + b] = d[8*b +: 8];
    endtask

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        int base;
        if (!ref_in_range(a)) return '0;
        base = (int'(a) / 4) * 4;
        return {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: handshake timeout", nm);
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly, input logic [1:0] exp_resp, input string tag);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int cyc = 0;
        bit in_rng = ref_in_range(addr);
        logic [1:0] resp;
        s_axi_awaddr = addr;
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            s_axi_awvalid = !aw_done && cyc >= aw_dly;
            s_axi_wvalid  = !w_done && cyc >= w_dly;
            @(negedge clka);
            if (!aw_done) chk({tag, " awready_high"}, s_axi_awready, 1);
            if (w_done)   chk({tag, " wready_low"}, s_axi_wready, 0);
            hs_aw = s_axi_awvalid && s_axi_awready;
            hs_w  = s_axi_wvalid && s_axi_wready;
            @(posedge clka); #1;
            aw_done = aw_done | hs_aw;
            w_done  = w_done | hs_w;
            cyc++;
        end
        s_axi_awvalid = 0;
        s_axi_wvalid  = 0;
        if (!(aw_done && w_done)) begin timeout({tag, " aw_w"}); return; end
        @(negedge clka);
        chk({tag, " grant_ena"}, bram_ena, in_rng);
        if (in_rng) begin
            chk({tag, " grant_wea"}, bram_wea, strb);
            chk({tag, " grant_addr"}, bram_addra, addr[BAW-1:0]);
            chk({tag, " grant_dina"}, bram_dina, data);
        end else begin
            chk({tag, " grant_wea"}, bram_wea, 0);
        end
        @(posedge clka); #1;
        s_axi_bready = (b_dly == 0);
        @(negedge clka);
        chk({tag, " bvalid"}, s_axi_bvalid, 1);
        chk({tag, " bresp"}, s_axi_bresp, exp_resp);
        resp = s_axi_bresp;
        for (int i = 0; i < b_dly; i++) begin
            @(posedge clka); #1;
            if (i == b_dly - 1) s_axi_bready = 1;
            @(negedge clka);
            chk({tag, " bvalid_hold"}, s_axi_bvalid, 1);
            chk({tag, " bresp_hold"}, s_axi_bresp, resp);
        end
        @(posedge clka); #1;
        s_axi_bready = 0;
        $display("WR %s addr=%h data=%h strb=%h bresp=%0d", tag, addr, data, strb, resp);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int r_dly,
                            input logic [DW-1:0] exp_data, input logic [1:0] exp_resp,
                            input string tag);
        bit hs = 0;
        int cyc = 0;
        bit in_rng = ref_in_range(addr);
        logic [DW-1:0] d;
        logic [1:0] r;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1;
        s_axi_rready  = (r_dly == 0);
        while (!hs && cyc < 50) begin
            @(negedge clka);
            if (s_axi_arready) begin
                hs = 1;
                chk({tag, " ar_ena"}, bram_ena, in_rng);
                chk({tag, " ar_wea"}, bram_wea, 0);
                if (in_rng) chk({tag, " ar_addr"}, bram_addra, addr[BAW-1:0]);
            end
            @(posedge clka); #1;
            cyc++;
        end
        s_axi_arvalid = 0;
        if (!hs) begin timeout({tag, " ar"}); return; end
        @(negedge clka);
        chk({tag, " rvalid_early"}, s_axi_rvalid, 0);
        @(posedge clka); #1;
        @(negedge clka);
        chk({tag, " rvalid"}, s_axi_rvalid, 1);
        chk({tag, " rdata"}, s_axi_rdata, exp_data);
        chk({tag, " rresp"}, s_axi_rresp, exp_resp);
        d = s_axi_rdata;
        r = s_axi_rresp;
        for (int i = 0; i < r_dly; i++) begin
            @(posedge clka); #1;
            if (i == r_dly - 1) s_axi_rready = 1;
            @(negedge clka);
            chk({tag, " rvalid_hold"}, s_axi_rvalid, 1);
            chk({tag, " rdata_hold"}, s_axi_rdata, d);
            chk({tag, " rresp_hold"}, s_axi_rresp, r);
        end
        @(posedge clka); #1;
        s_axi_rready = 0;
        @(negedge clka);
        chk({tag, " rvalid_drop"}, s_axi_rvalid, 0);
        @(posedge clka); #1;
        $display("RD %s addr=%h rdata=%h rresp=%0d", tag, addr, d, r);
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          resp_dly;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [3:0]    s;

        vecs[0]  = '{1, 32'h10,       32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0};
        vecs[1]  = '{0, 32'h10,       32'h0,        4'h0, 0, 0, 0, 2'b00, 32'hDEADBEEF};
        vecs[2]  = '{1, 32'h10,       32'h000000AA, 4'h1, 3, 0, 0, 2'b00, 32'h0};
        vecs[3]  = '{0, 32'h10,       32'h0,        4'h0, 0, 0, 0, 2'b00, 32'hDEADBEAA};
        vecs[4]  = '{0, 32'h200,      32'h0,        4'h0, 0, 0, 0, 2'b11, 32'h0};
        vecs[5]  = '{1, 32'h80,       32'h11111111, 4'hF, 0, 0, 1, 2'b11, 32'h0};
        vecs[6]  = '{1, 32'h7C,       32'h12345678, 4'hC, 1, 2, 0, 2'b00, 32'h0};
        vecs[7]  = '{0, 32'h7F,       32'h0,        4'h0, 0, 0, 5, 2'b00, 32'h12340000};
        vecs[8]  = '{1, 32'h10,       32'hFFFFFFFF, 4'h0, 0, 0, 0, 2'b00, 32'h0};
        vecs[9]  = '{0, 32'h13,       32'h0,        4'h0, 0, 0, 0, 2'b00, 32'hDEADBEAA};
        vecs[10] = '{0, 32'hFFFFFFFC, 32'h0,        4'h0, 0, 0, 2, 2'b11, 32'h0};
        vecs[11] = '{0, 32'h00,       32'h0,        4'h0, 0, 0, 0, 2'b00, 32'h0};

        rstn = 0;
        s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 0; s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0;
        s_axi_rready = 0;

        #12;
        chk("rst awready", s_axi_awready, 0);
        chk("rst wready", s_axi_wready, 0);
        chk("rst arready", s_axi_arready, 0);
        chk("rst bvalid", s_axi_bvalid, 0);
        chk("rst rvalid", s_axi_rvalid, 0);
        chk("rst ena", bram_ena, 0);
        chk("rst wea", bram_wea, 0);
        chk("rst rdata", s_axi_rdata, 0);
        chk("rst rresp", s_axi_rresp, 0);
        chk("rst bresp", s_axi_bresp, 0);
        #11 rstn = 1;
        @(posedge clka); #1;
        @(posedge clka); #1;
        @(negedge clka);
        chk("post_rst awready", s_axi_awready, 1);
        chk("post_rst arready", s_axi_arready, 1);
        @(posedge clka); #1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly,
                          vecs[i].w_dly, vecs[i].resp_dly, vecs[i].exp_resp,
                          $sformatf("vec%0d", i));
                ref_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            end else begin
                axi_read(vecs[i].addr, vecs[i].resp_dly, vecs[i].exp_rdata,
                         vecs[i].exp_resp, $sformatf("vec%0d", i));
            end
        end

        // Last op was a read: a held write must win against a new AR.
        s_axi_awaddr = 32'h20; s_axi_wdata = 32'hCAFEF00D; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        @(negedge clka);
        chk("arbW aw_hs", s_axi_awready, 1);
        chk("arbW w_hs", s_axi_wready, 1);
        @(posedge clka); #1;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        s_axi_araddr = 32'h20; s_axi_arvalid = 1; s_axi_rready = 1;
        @(negedge clka);
        chk("arbW arready", s_axi_arready, 0);
        chk("arbW ena", bram_ena, 1);
        chk("arbW wea", bram_wea, 4'hF);
        @(posedge clka); #1;
        s_axi_bready = 1;
        @(negedge clka);
        chk("arbW bvalid", s_axi_bvalid, 1);
        chk("arbW arready_busy", s_axi_arready, 0);
        @(posedge clka); #1;
        s_axi_bready = 0;
        ref_write(32'h20, 32'hCAFEF00D, 4'hF);
        @(negedge clka);
        chk("arbW rd_arready", s_axi_arready, 1);
        chk("arbW rd_ena", bram_ena, 1);
        chk("arbW rd_wea", bram_wea, 0);
        @(posedge clka); #1;
        s_axi_arvalid = 0;
        @(negedge clka);
        chk("arbW rvalid_early", s_axi_rvalid, 0);
        @(posedge clka); #1;
        @(negedge clka);
        chk("arbW rvalid", s_axi_rvalid, 1);
        chk("arbW rdata", s_axi_rdata, 32'hCAFEF00D);
        @(posedge clka); #1;
        s_axi_rready = 0;
        $display("ARB write-first sequence done rdata=%h", s_axi_rdata);

        axi_write(32'h24, 32'h55AA55AA, 4'hF, 0, 0, 0, 2'b00, "arb_prep");
        ref_write(32'h24, 32'h55AA55AA, 4'hF);

        // Last op was a write: AR must win against the held pair.
        s_axi_awaddr = 32'h20; s_axi_wdata = 32'h0BADC0DE; s_axi_wstrb = 4'h3;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        @(negedge clka);
        chk("arbR aw_hs", s_axi_awready, 1);
        @(posedge clka); #1;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        s_axi_araddr = 32'h20; s_axi_arvalid = 1; s_axi_rready = 1;
        @(negedge clka);
        chk("arbR arready", s_axi_arready, 1);
        chk("arbR ena", bram_ena, 1);
        chk("arbR wea", bram_wea, 0);
        @(posedge clka); #1;
        s_axi_arvalid = 0;
        @(negedge clka);
        chk("arbR idle_ena", bram_ena, 0);
        @(posedge clka); #1;
        @(negedge clka);
        chk("arbR rvalid", s_axi_rvalid, 1);
        chk("arbR rdata_old", s_axi_rdata, 32'hCAFEF00D);
        @(posedge clka); #1;
        s_axi_rready = 0;
        @(negedge clka);
        chk("arbR wr_ena", bram_ena, 1);
        chk("arbR wr_wea", bram_wea, 4'h3);
        chk("arbR wr_addr", bram_addra, 7'h20);
        @(posedge clka); #1;
        s_axi_bready = 1;
        @(negedge clka);
        chk("arbR bvalid", s_axi_bvalid, 1);
        chk("arbR bresp", s_axi_bresp, 0);
        @(posedge clka); #1;
        s_axi_bready = 0;
        ref_write(32'h20, 32'h0BADC0DE, 4'h3);
        $display("ARB read-first sequence done");
        axi_read(32'h20, 0, 32'hCAFEC0DE, 2'b00, "arbR_after");

        // Reset while a read response is pending and an AW is held.
        s_axi_awaddr = 32'h30; s_axi_awvalid = 1;
        @(negedge clka);
        chk("rstseq aw_hs", s_axi_awready, 1);
        @(posedge clka); #1;
        s_axi_awvalid = 0;
        s_axi_araddr = 32'h10; s_axi_arvalid = 1; s_axi_rready = 0;
        @(negedge clka);
        chk("rstseq ar_hs", s_axi_arready, 1);
        @(posedge clka); #1;
        s_axi_arvalid = 0;
        @(negedge clka);
        @(posedge clka); #1;
        @(negedge clka);
        chk("rstseq rvalid_pre", s_axi_rvalid, 1);
        chk("rstseq awready_pre", s_axi_awready, 0);
        #2 rstn = 0;
        #1;
        chk("rstseq rvalid", s_axi_rvalid, 0);
        chk("rstseq awready", s_axi_awready, 0);
        chk("rstseq wready", s_axi_wready, 0);
        chk("rstseq arready", s_axi_arready, 0);
        chk("rstseq ena", bram_ena, 0);
        chk("rstseq rdata", s_axi_rdata, 0);
        @(negedge clka);
        #2 rstn = 1;
        @(posedge clka); #1;
        @(posedge clka); #1;
        s_axi_rready = 1; s_axi_bready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clka);
            chk("rstseq awready_after", s_axi_awready, 1);
            chk("rstseq wready_after", s_axi_wready, 1);
            chk("rstseq rvalid_after", s_axi_rvalid, 0);
            chk("rstseq bvalid_after", s_axi_bvalid, 0);
            chk("rstseq ena_after", bram_ena, 0);
            @(posedge clka); #1;
        end
        s_axi_rready = 0; s_axi_bready = 0;
        $display("RST mid-transaction sequence done");
        axi_read(32'h30, 0, ref_read(32'h30), 2'b00, "rst_after");

        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 2), ref_in_range(a) ? 2'b00 : 2'b11,
                          $sformatf("rnd%0d", i));
                ref_write(a, d, s);
            end else begin
                axi_read(a, $urandom_range(0, 2), ref_read(a),
                         ref_in_range(a) ? 2'b00 : 2'b11, $sformatf("rnd%0d", i));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_bram_ctrl.md
Name: axi_lite_bram_ctrl

Overview:
AXI4-Lite slave front end that converts single-beat AXI reads and writes into accesses on the native single-port BRAM interface. The BRAM interface has a byte address, per-byte write enables, and read data valid one cycle after the enabled access. This block sits directly upstream of the BRAM and owns the BRAM port exclusively. It performs address range checking, write-address/write-data joining, read/write arbitration and response buffering.

Parameters:
MEM_DATA_WIDTH, 32, AXI data width and BRAM word width in bits; must be a multiple of 8.
BRAM_ADDR_WIDTH, 7, BRAM byte-address width; 128 B per 32-bit configuration.
AXI_ADDR_WIDTH, 32, AXI address width; must be >= BRAM_ADDR_WIDTH.

Ports:
clka  in  1  clock; all logic on the rising edge.
rstn  in  1  asynchronous active-low reset.
s_axi_awaddr  in  AXI_ADDR_WIDTH  write address.
s_axi_awvalid/s_axi_awready  in/out  1  AW handshake.
s_axi_wdata  in  MEM_DATA_WIDTH  write data.
s_axi_wstrb  in  MEM_DATA_WIDTH/8  byte strobes.
s_axi_wvalid/s_axi_wready  in/out  1  W handshake.
s_axi_bresp  out  2  write response.
s_axi_bvalid/s_axi_bready  out/in  1  B handshake.
s_axi_araddr  in  AXI_ADDR_WIDTH  read address.
s_axi_arvalid/s_axi_arready  in/out  1  AR handshake.
s_axi_rdata  out  MEM_DATA_WIDTH  read data.
s_axi_rresp  out  2  read response.
s_axi_rvalid/s_axi_rready  out/in  1  R handshake.
bram_addra  out  BRAM_ADDR_WIDTH  BRAM byte address.
bram_ena  out  1  BRAM access enable.
bram_wea  out  MEM_DATA_WIDTH/8  BRAM byte write enables.
bram_dina  out  MEM_DATA_WIDTH  BRAM write data.
bram_douta  in  MEM_DATA_WIDTH  BRAM read data; valid the cycle after an enabled access.

Behaviour:
- Reset (async assert, sync release): all state cleared; FSM=IDLE; aw_held=w_held=0; last_was_read=0.
  - Outputs during and after reset: all valid/ready outputs 0, bram_ena=0, bram_wea=0, rdata=0, rresp=bresp=0.
  - In-flight transactions are dropped without responses.
- Write capture:
  - awready = ~aw_held; wready = ~w_held. Both are registered, combinational only on held flags.
  - AW and W are accepted independently, in any order or the same cycle, into holding registers.
  - A new AW/W beat is not accepted until the held pair has been executed.
- FSM states: IDLE, RD_ACCESS, RD_RESP, WR_RESP.
- IDLE arbitration, when a read is pending (arvalid) and a write is ready (aw_held & w_held, i.e. both already registered):
  - Grant write if last_was_read=1, else grant read (alternating priority).
  - With a single requester, grant it.
  - arready = (state==IDLE) & ~(write granted this cycle).
- Read, AR handshake at cycle N:
  - If araddr[AXI_ADDR_WIDTH-1:BRAM_ADDR_WIDTH]==0: bram_ena=1, bram_wea=0, bram_addra=araddr[BRAM_ADDR_WIDTH-1:0] combinationally in cycle N. Otherwise no BRAM access; mark decerr.
  - Go to RD_ACCESS; set last_was_read=1.
  - RD_ACCESS (N+1): capture bram_douta (or 0 if decerr) into the rdata register; rresp = decerr ? 2'b11 : 2'b00; go to RD_RESP.
  - RD_RESP: rvalid=1 from N+2; hold rdata/rresp stable until rready; on handshake return to IDLE.
- Write execute, granted at cycle M:
  - In range: bram_ena=1, bram_wea=held wstrb, bram_addra=held awaddr low bits, bram_dina=held wdata in cycle M.
  - Out of range: no BRAM access; bresp=2'b11.
  - Clear aw_held/w_held; set last_was_read=0; go to WR_RESP. bvalid=1 from M+1 until bready, then IDLE.
  - wstrb==0: BRAM enabled with wea=0; OKAY response.
- Address alignment: the low $clog2(MEM_DATA_WIDTH/8) address bits pass through unchanged; the BRAM ignores them. No misalignment error.
- Outside granted cycles: bram_ena=0 and bram_wea=0. bram_dina/bram_addra are don't-care when ena=0.
- Only one outstanding transaction; no AR is accepted while in RD_*/WR_RESP. AW/W may still be captured.
- Minimum turnaround: read 3 cycles AR-to-next-AR with rready tied high; write 2 cycles grant-to-next-grant.

Test Plan:
1. Reset then write awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF, AW and W same cycle -> grant next cycle with bram_ena=1, bram_addra=0x10, bram_wea=0xF; bvalid one cycle later, bresp=0.
2. Read araddr=0x10 with rready=1 -> bram_ena pulse in the AR cycle; rvalid 2 cycles later with rdata=0xDEADBEEF, rresp=0.
3. W first (wdata=0x000000AA, wstrb=0x1), AW 3 cycles later at 0x10; then read 0x10 -> rdata=0xDEADBEAA; awready was 1 until its handshake and wready dropped after its handshake.
4. Read araddr=0x200 (BRAM_ADDR_WIDTH=7) -> no bram_ena; rresp=2'b11, rdata=0. Write awaddr=0x80 -> no bram_ena; bresp=2'b11.
5. Write pair held and arvalid asserted together, with last_was_read=0 -> read granted first, then write. Repeat with last_was_read=1 -> write granted first. Hold rready=0 for 5 cycles -> rvalid and rdata stable throughout.
6. Assert rstn=0 while in RD_RESP with aw_held=1 -> rvalid, awready, wready and bram_ena go 0 immediately. After release: IDLE, awready=1, no stale B/R response.
